// File: rtl/queen_stack_controller_if.sv
// Solver/RAM-side bundle for the queen position stack controller.
// slave = controller side; master = solver request lines plus the RAM read-data return.
interface queen_stack_controller_if #(
  parameter int WIDTH  = 6,
  parameter int ADDR_W = 3
);
  logic              push;
  logic              pop;
  logic              clear;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;
  logic              stack_ready;
  logic              underflow;
  logic              overflow;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_rdata;

  modport slave (
    input  push, pop, clear, data_in, mem_rdata,
    output data_out, stack_ready, underflow, overflow, empty, full, count,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output push, pop, clear, data_in, mem_rdata,
    input  data_out, stack_ready, underflow, overflow, empty, full, count,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/queen_stack_controller.sv
// Push/pop sequencer for the queen position RAM; push takes 2 cycles, pop 3 cycles.
// Requests are only sampled while stack_ready=1; anything arriving while busy is dropped, not queued.
module queen_stack_controller #(
  parameter int WIDTH  = 6,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     user_reset,
  queen_stack_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_ADDR, READ_DATA} state_t;

  localparam logic [ADDR_W:0] SP_MAX = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   sp, sp_nxt;
  logic [ADDR_W-1:0] sp_dec;
  logic [WIDTH-1:0]  wdata, wdata_nxt;
  logic [WIDTH-1:0]  dout, dout_nxt;
  logic              uflow, uflow_nxt;
  logic              oflow, oflow_nxt;
  logic              empty, full;

  assign empty  = (sp == '0);
  assign full   = (sp == SP_MAX);
  assign sp_dec = sp[ADDR_W-1:0] - 1'b1;

  always_comb begin
    state_nxt = state;
    sp_nxt    = sp;
    wdata_nxt = wdata;
    dout_nxt  = dout;
    uflow_nxt = uflow;
    oflow_nxt = oflow;
    case (state)
      IDLE: begin
        // push has priority; a simultaneous pop is dropped without flagging
        if (bus.push) begin
          if (!full) begin
            wdata_nxt = bus.data_in;
            uflow_nxt = 1'b0;
            state_nxt = WRITE;
          end else begin
            oflow_nxt = 1'b1;
          end
        end else if (bus.pop) begin
          if (!empty) begin
            oflow_nxt = 1'b0;
            state_nxt = READ_ADDR;
          end else begin
            uflow_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        sp_nxt    = sp + 1'b1;
        state_nxt = IDLE;
      end
      READ_ADDR: begin
        sp_nxt    = sp - 1'b1;
        state_nxt = READ_DATA;
      end
      READ_DATA: begin
        dout_nxt  = bus.mem_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // flush keeps the last popped value; an in-flight RAM write still completes
    if (bus.clear) begin
      state_nxt = IDLE;
      sp_nxt    = '0;
      uflow_nxt = 1'b0;
      oflow_nxt = 1'b0;
      dout_nxt  = dout;
    end
  end

  always_ff @(posedge clk) begin
    if (user_reset) begin
      state <= IDLE;
      sp    <= '0;
      wdata <= '0;
      dout  <= '0;
      uflow <= 1'b0;
      oflow <= 1'b0;
    end else begin
      state <= state_nxt;
      sp    <= sp_nxt;
      wdata <= wdata_nxt;
      dout  <= dout_nxt;
      uflow <= uflow_nxt;
      oflow <= oflow_nxt;
    end
  end

  always_comb begin
    bus.mem_addr = sp[ADDR_W-1:0];
    if (state == READ_ADDR) bus.mem_addr = sp_dec;
  end

  assign bus.mem_we      = (state == WRITE);
  assign bus.mem_wdata   = wdata;
  assign bus.stack_ready = (state == IDLE);
  assign bus.data_out    = dout;
  assign bus.underflow   = uflow;
  assign bus.overflow    = oflow;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.count       = sp;

endmodule

// File: tb/tb_queen_stack_controller.sv
// Directed bench for queen_stack_controller with a behavioural 1-cycle-latency RAM.
module tb_queen_stack_controller;
  logic clk = 1'b0;
  logic user_reset;
  int   checks = 0;
  int   errors = 0;
  logic [5:0] ram [8];

  always #5 clk = ~clk;

  queen_stack_controller_if #(.WIDTH(6), .ADDR_W(3)) bus ();

  queen_stack_controller #(.WIDTH(6), .DEPTH(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .user_reset (user_reset),
    .bus        (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [5:0] d);
    bus.push = 1'b1; bus.data_in = d;
    tick();
    bus.push = 1'b0;
    tick();
  endtask

  task automatic do_pop();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; bus.data_in = '0;
    user_reset = 1'b1;
    tick();
    tick();
    user_reset = 1'b0;

    // reset state
    check("rst_ready", bus.stack_ready, 1);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_count", bus.count, 0);
    check("rst_dout", bus.data_out, 0);
    check("rst_uflow", bus.underflow, 0);
    check("rst_oflow", bus.overflow, 0);

    // 1: single push
    bus.push = 1'b1; bus.data_in = 6'h05;
    tick();
    bus.push = 1'b0;
    check("t1_we", bus.mem_we, 1);
    check("t1_addr", bus.mem_addr, 0);
    check("t1_wdata", bus.mem_wdata, 6'h05);
    check("t1_ready_lo", bus.stack_ready, 0);
    tick();
    check("t1_ready_hi", bus.stack_ready, 1);
    check("t1_we_off", bus.mem_we, 0);
    check("t1_count", bus.count, 1);
    check("t1_ram0", ram[0], 6'h05);

    // 2: LIFO order
    do_reset();
    do_push(6'h01); do_push(6'h0A); do_push(6'h13);
    check("t2_count3", bus.count, 3);
    bus.pop = 1'b1;
    tick();
    check("t2_raddr", bus.mem_addr, 2);
    check("t2_rwe", bus.mem_we, 0);
    check("t2_rready", bus.stack_ready, 0);
    tick();                       // pop still high in READ_DATA: must be ignored
    bus.pop = 1'b0;
    check("t2_daddr", bus.mem_addr, 2);
    tick();
    check("t2_pop1", bus.data_out, 6'h13);
    check("t2_cnt_after1", bus.count, 2);
    do_pop();
    check("t2_pop2", bus.data_out, 6'h0A);
    do_pop();
    check("t2_pop3", bus.data_out, 6'h01);
    check("t2_empty", bus.empty, 1);

    // 3: underflow
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("t3_uflow", bus.underflow, 1);
    check("t3_ready", bus.stack_ready, 1);
    check("t3_we", bus.mem_we, 0);
    check("t3_count", bus.count, 0);
    do_push(6'h07);
    check("t3_uflow_clr", bus.underflow, 0);
    check("t3_count1", bus.count, 1);

    // 4: fill and overflow
    do_reset();
    for (int i = 0; i < 8; i++) do_push(6'(6'h20 + i));
    check("t4_full", bus.full, 1);
    check("t4_count8", bus.count, 8);
    check("t4_addr_wrap", bus.mem_addr, 0);
    bus.push = 1'b1; bus.data_in = 6'h3F;
    tick();
    bus.push = 1'b0;
    check("t4_oflow", bus.overflow, 1);
    check("t4_no_we", bus.mem_we, 0);
    check("t4_ready", bus.stack_ready, 1);
    check("t4_count_hold", bus.count, 8);
    do_pop();
    check("t4_pop8", bus.data_out, 6'h27);
    check("t4_oflow_clr", bus.overflow, 0);
    check("t4_count7", bus.count, 7);

    // 5: push wins over simultaneous pop
    do_reset();
    do_push(6'h11); do_push(6'h22);
    bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 6'h33;
    tick();
    bus.push = 1'b0; bus.pop = 1'b0;
    check("t5_we", bus.mem_we, 1);
    check("t5_addr", bus.mem_addr, 2);
    tick();
    check("t5_count3", bus.count, 3);
    tick();
    check("t5_no_read", bus.stack_ready, 1);
    check("t5_uflow", bus.underflow, 0);
    check("t5_ram2", ram[2], 6'h33);

    // 6: clear during READ_ADDR, then reset during WRITE
    do_push(6'h2A); do_push(6'h15);
    do_pop();
    check("t6_dout", bus.data_out, 6'h15);
    check("t6_count4", bus.count, 4);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("t6_raddr", bus.mem_addr, 3);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("t6_clr_ready", bus.stack_ready, 1);
    check("t6_clr_count", bus.count, 0);
    check("t6_clr_dout", bus.data_out, 6'h15);
    check("t6_clr_empty", bus.empty, 1);

    bus.push = 1'b1; bus.data_in = 6'h3C;
    tick();
    bus.push = 1'b0;
    check("t6_write", bus.mem_we, 1);
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    check("t6_rst_ready", bus.stack_ready, 1);
    check("t6_rst_count", bus.count, 0);
    check("t6_rst_dout", bus.data_out, 0);
    check("t6_rst_we", bus.mem_we, 0);
    check("t6_rst_addr", bus.mem_addr, 0);
    check("t6_rst_wdata", bus.mem_wdata, 0);
    check("t6_rst_empty", bus.empty, 1);
    check("t6_rst_full", bus.full, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
